pd_rx_gather: RTL and testbench

Receive-side consumer for the lane byte-valid words produced by the generation/lane controller. Each write carries a 512-bit lane word and a 64-bit byte-valid mask, sized by current gen, PIPE width and detected lane count. The block buffers these words and serializes them into a fixed-width beat stream with byte enables and start/end markers toward the data link layer. It sits between the physical-layer lane buffer and the DLL receive path.

---
 rtl/pd_rx_pkg.sv | 38 +++
 rtl/pd_rx_fifo.sv | 79 +++++++
 rtl/pd_rx_gather.sv | 199 +++++++++++++++++++
 tb/tb_pd_rx_gather.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_rx_pkg.sv
// Shared types and helpers for the lane-word receive gather path.
package pd_rx_pkg;

  localparam int unsigned MAX_LANE_BYTES = 64;
  localparam int unsigned LANE_BITS      = MAX_LANE_BYTES * 8;
  localparam int unsigned NW             = 7;

  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [LANE_BITS-1:0] data;
    logic [NW-1:0]        n;
  } rx_entry_t;

  // Length of the run of ones starting at bit 0; bits past the first zero are ignored.
  function automatic logic [NW-1:0] trailing_ones(input logic [MAX_LANE_BYTES-1:0] mask);
    logic [NW-1:0] cnt;
    logic          run;
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANE_BYTES; i++) begin
      run = run & mask[i];
      cnt = cnt + NW'(run);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pd_rx_fifo.sv
// Lane-word FIFO: entry storage, pointers, registered occupancy/full/empty, sync clear.
module pd_rx_fifo
  import pd_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  rx_entry_t     i_wdata,
  output rx_entry_t     o_head,
  output rx_entry_t     o_head_nxt,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Payload storage carries no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_head_nxt = r_mem[r_rd_ptr + AW'(1)];
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

// File: rtl/pd_rx_gather.sv
// Buffers lane words and serializes them into OUT_BYTES-wide beats with enables and sop/eop.
// Optional byte counter port when PD_RX_GATHER_STATS_EN is defined.
module pd_rx_gather
  import pd_rx_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OUT_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w,
  input  logic [LANE_BITS-1:0]      data_in,
  input  logic [MAX_LANE_BYTES-1:0] valid,
  input  logic                      linkup,
  output logic                      full,
  output logic                      overflow,
  output logic [OUT_BYTES*8-1:0]    out_data,
  output logic [OUT_BYTES-1:0]      out_be,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sop,
  output logic                      out_eop
`ifdef PD_RX_GATHER_STATS_EN
  ,
  output logic [31:0]               byte_count
`endif
);

  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned OBW      = OUT_BYTES * 8;
  localparam int unsigned OBW1     = OUT_BYTES + 1;
  localparam int unsigned OB_SHIFT = $clog2(OUT_BYTES);

  function automatic logic [NW-1:0] num_beats(input logic [NW-1:0] n);
    return NW'((8'(n) + 8'(OUT_BYTES - 1)) >> OB_SHIFT);
  endfunction

  rx_state_e          r_state;
  logic [NW-1:0]      r_beat;
  logic               r_out_valid;
  logic [OBW-1:0]     r_out_data;
  logic [OUT_BYTES-1:0] r_out_be;
  logic               r_out_sop;
  logic               r_out_eop;
  logic               r_overflow;

  rx_entry_t          w_in_ent;
  rx_entry_t          w_head;
  rx_entry_t          w_head_nxt;
  logic [CW-1:0]      w_count;
  logic               w_full;
  logic               w_empty;
  logic [NW-1:0]      w_n;
  logic               w_push;
  logic               w_drop;
  logic               w_acc;
  logic               w_head_last;
  logic               w_pop;

  logic               w_nxt_vld;
  rx_entry_t          w_nxt_ent;
  logic [NW-1:0]      w_nxt_beat;
  logic [NW-1:0]      w_nxt_beats;
  logic               w_nxt_last;
  logic [NW-1:0]      w_rem;
  logic [OBW1-1:0]    w_one_hot;
  logic [OUT_BYTES-1:0] w_nxt_be;
  logic [12:0]        w_shift;
  logic [OBW-1:0]     w_nxt_data;

  assign w_n         = trailing_ones(valid);
  assign w_in_ent    = '{data: data_in, n: w_n};
  assign w_push      = w & linkup & !w_full & (w_n != '0);
  assign w_drop      = w & linkup & w_full;
  assign w_acc       = r_out_valid & out_ready;
  assign w_head_last = (r_beat == num_beats(w_head.n) - NW'(1));
  assign w_pop       = w_acc & w_head_last;

  pd_rx_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (!linkup),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wdata    (w_in_ent),
    .o_head     (w_head),
    .o_head_nxt (w_head_nxt),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Pick the entry presented next cycle; an empty FIFO bypasses the incoming word.
  always_comb begin
    w_nxt_vld = 1'b0;
    w_nxt_ent = w_head;
    if (w_pop) begin
      if (w_count >= CW'(2)) begin
        w_nxt_vld = 1'b1;
        w_nxt_ent = w_head_nxt;
      end else if (w_push) begin
        w_nxt_vld = 1'b1;
        w_nxt_ent = w_in_ent;
      end
    end else if (!w_empty) begin
      w_nxt_vld = 1'b1;
    end else if (w_push) begin
      w_nxt_vld = 1'b1;
      w_nxt_ent = w_in_ent;
    end
  end

  always_comb begin
    w_nxt_beat = r_beat;
    if (w_acc && !w_head_last) begin
      w_nxt_beat = r_beat + NW'(1);
    end else if (w_pop) begin
      w_nxt_beat = '0;
    end
  end

  assign w_nxt_beats = num_beats(w_nxt_ent.n);
  assign w_nxt_last  = (w_nxt_beat == w_nxt_beats - NW'(1));
  assign w_rem       = w_nxt_ent.n - NW'(w_nxt_beat << OB_SHIFT);
  assign w_one_hot   = OBW1'(1) << w_rem;
  assign w_nxt_be    = w_nxt_last ? OUT_BYTES'(w_one_hot - OBW1'(1)) : '1;
  assign w_shift     = 13'(w_nxt_beat) << (OB_SHIFT + 3);
  assign w_nxt_data  = OBW'(w_nxt_ent.data >> w_shift);

  // FSM plus registered beat outputs; recomputing from unchanged head/beat keeps a stalled beat stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_be    <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (!linkup) begin
        r_state     <= FLUSH;
        r_beat      <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_be    <= '0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
      end else begin
        case (r_state)
          IDLE:    if (w_nxt_vld) r_state <= DRAIN;
          DRAIN:   if (!w_nxt_vld) r_state <= IDLE;
          FLUSH:   r_state <= w_nxt_vld ? DRAIN : IDLE;
          default: r_state <= IDLE;
        endcase
        r_beat      <= w_nxt_vld ? w_nxt_beat : '0;
        r_out_valid <= w_nxt_vld;
        r_out_data  <= w_nxt_vld ? w_nxt_data : '0;
        r_out_be    <= w_nxt_vld ? w_nxt_be : '0;
        r_out_sop   <= w_nxt_vld & (w_nxt_beat == '0);
        r_out_eop   <= w_nxt_vld & w_nxt_last;
      end
    end
  end

  assign full      = w_full;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_be    = r_out_be;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;

`ifdef PD_RX_GATHER_STATS_EN
  logic [31:0] r_byte_count;
  logic [32:0] w_byte_sum;

  assign w_byte_sum = {1'b0, r_byte_count} + 33'($countones(r_out_be));

  // Saturating count of bytes delivered downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_count <= '0;
    end else if (w_acc) begin
      r_byte_count <= w_byte_sum[32] ? '1 : w_byte_sum[31:0];
    end
  end

  assign byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_pd_rx_gather.sv
// Self-checking bench for pd_rx_gather: vector table plus multi-cycle corner sequences.
module tb_pd_rx_gather;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OB    = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         w;
  logic [511:0] data_in;
  logic [63:0]  valid;
  logic         linkup;
  logic         full;
  logic         overflow;
  logic [63:0]  out_data;
  logic [7:0]   out_be;
  logic         out_valid;
  logic         out_ready;
  logic         out_sop;
  logic         out_eop;
`ifdef PD_RX_GATHER_STATS_EN
  logic [31:0]  byte_count;
`endif

  pd_rx_gather #(
    .DEPTH     (DEPTH),
    .OUT_BYTES (OB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .w         (w),
    .data_in   (data_in),
    .valid     (valid),
    .linkup    (linkup),
    .full      (full),
    .overflow  (overflow),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
`ifdef PD_RX_GATHER_STATS_EN
    , .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [7:0]  be;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic [63:0] v;
    int          n;
  } vec_t;

  beat_t  sb[$];
  int     checks    = 0;
  int     failures  = 0;
  int     eop_cnt   = 0;
  longint exp_bytes = 0;
  beat_t  got;
  beat_t  expd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  task automatic enqueue(input logic [511:0] d, input int n);
    int    beats;
    int    rem;
    beat_t b;
    beats = (n + 7) / 8;
    for (int k = 0; k < beats; k++) begin
      rem    = n - 8 * k;
      b.data = 64'(d >> (k * 64));
      b.be   = (rem >= 8) ? 8'hFF : 8'((32'd1 << rem) - 1);
      b.sop  = (k == 0);
      b.eop  = (k == beats - 1);
      sb.push_back(b);
    end
  endtask

  task automatic push_word(input logic [63:0] v, input logic [511:0] d, input int n, input bit accept);
    w       = 1'b1;
    valid   = v;
    data_in = d;
    if (accept && n > 0) enqueue(d, n);
    tick();
    w     = 1'b0;
    valid = '0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    check({name, "_drain"}, 128'(done), 128'(1'b1));
  endtask

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got = '{sop: out_sop, eop: out_eop, be: out_be, data: out_data};
      if (out_eop) eop_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", got);
      end else begin
        expd = sb.pop_front();
        exp_bytes += $countones(expd.be);
        check("beat", 128'(got), 128'(expd));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[8];
    logic [511:0] d;
    logic [74:0]  snap;
    int           run;
    int           e0;

    tbl[0] = '{v: 64'h1,                   n: 1};
    tbl[1] = '{v: 64'hFFFF_FFFF_FFFF_FFFF, n: 64};
    tbl[2] = '{v: 64'h0FFF,                n: 12};
    tbl[3] = '{v: 64'h0F0F,                n: 4};
    tbl[4] = '{v: 64'hFFFF_FFFF_FFFF_FFFE, n: 0};
    tbl[5] = '{v: 64'h7F,                  n: 7};
    tbl[6] = '{v: 64'h1FF,                 n: 9};
    tbl[7] = '{v: 64'hFF,                  n: 8};

    reset     = 1'b1;
    w         = 1'b0;
    valid     = '0;
    data_in   = '0;
    linkup    = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_valid",    128'(out_valid), 128'(0));
    check("rst_sop",      128'(out_sop),   128'(0));
    check("rst_eop",      128'(out_eop),   128'(0));
    check("rst_be",       128'(out_be),    128'(0));
    check("rst_data",     128'(out_data),  128'(0));
    check("rst_full",     128'(full),      128'(0));
    check("rst_overflow", 128'(overflow),  128'(0));
    tick();
    reset = 1'b0;
    tick();

    // Vector table: one word each, latency and beat stream checked.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = rand512();
      if (i == 0) d[7:0] = 8'hA5;
      push_word(tbl[i].v, d, tbl[i].n, 1'b1);
      @(negedge clk);
      check($sformatf("lat_valid_%0d", i), 128'(out_valid), 128'(tbl[i].n != 0));
      check($sformatf("lat_sop_%0d", i),   128'(out_sop),   128'(tbl[i].n != 0));
      tick();
      wait_drain($sformatf("vec%0d", i));
      tick();
    end

    // Two back-to-back full words: 16 beats without a gap.
    push_word('1, rand512(), 64, 1'b1);
    push_word('1, rand512(), 64, 1'b1);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid) run++;
    end
    check("nobubble_run", 128'(run), 128'(15));
    wait_drain("nobubble");
    tick();

    // Backpressure mid-word: stalled beat must hold bit-stable.
    push_word('1, rand512(), 64, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    snap = {out_valid, out_sop, out_eop, out_be, out_data};
    check("bp_held_valid", 128'(out_valid), 128'(1));
    check("bp_held_be",    128'(out_be),    128'(8'hFF));
    check("bp_held_sop",   128'(out_sop),   128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_stable_%0d", i), 128'({out_valid, out_sop, out_eop, out_be, out_data}), 128'(snap));
    end
    tick();
    out_ready = 1'b1;
    wait_drain("bp");
    tick();

    // Asynchronous reset in the middle of a word.
    push_word('1, rand512(), 64, 1'b1);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'(0));
    check("arst_eop",   128'(out_eop),   128'(0));
    check("arst_be",    128'(out_be),    128'(0));
    check("arst_data",  128'(out_data),  128'(0));
    sb.delete();
    exp_bytes = 0;
    tick();
    reset = 1'b0;
    tick();

    // Overflow: four words fill the FIFO, the fifth is dropped.
    out_ready = 1'b0;
    e0 = eop_cnt;
    for (int i = 0; i < 4; i++) begin
      push_word(64'hFFFF, rand512(), 16, 1'b1);
      @(negedge clk);
      check($sformatf("ovf_full_%0d", i), 128'(full), 128'(i == 3));
      tick();
    end
    check("ovf_pre_overflow", 128'(overflow), 128'(0));
    push_word(64'hFFFF, rand512(), 16, 1'b0);
    @(negedge clk);
    check("ovf_overflow", 128'(overflow), 128'(1));
    check("ovf_still_full", 128'(full), 128'(1));
    tick();
    out_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_words", 128'(eop_cnt - e0), 128'(4));
    check("ovf_full_after", 128'(full), 128'(0));
    tick();

    // Flush mid-word with a full FIFO, then recover.
    e0 = eop_cnt;
    for (int i = 0; i < 4; i++) push_word('1, rand512(), 64, 1'b1);
    @(negedge clk);
    check("fl_full_before", 128'(full), 128'(1));
    #1;
    linkup = 1'b0;
    tick();
    sb.delete();
    @(negedge clk);
    check("fl_valid", 128'(out_valid), 128'(0));
    check("fl_full",  128'(full),      128'(0));
    check("fl_eop",   128'(out_eop),   128'(0));
    check("fl_no_eop_seen", 128'(eop_cnt - e0), 128'(0));
    tick();
    @(negedge clk);
    check("fl_hold_valid", 128'(out_valid), 128'(0));
    tick();
    linkup = 1'b1;
    tick();
    push_word(64'hFF, rand512(), 8, 1'b1);
    @(negedge clk);
    check("fl_new_valid",    128'(out_valid), 128'(1));
    check("fl_new_sop",      128'(out_sop),   128'(1));
    check("fl_overflow_kept", 128'(overflow), 128'(1));
    tick();
    wait_drain("fl");

`ifdef PD_RX_GATHER_STATS_EN
    check("byte_count", 128'(byte_count), 128'(exp_bytes));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
